// File: rtl/dt1_muldiv_pkg.sv
// dt1 execute-stage shared encodings: M-extension funct3 codes,
// muldiv FSM states and ALU control codes.
package dt1_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } md_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  function automatic logic op_sgn_a(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_sgn_b(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/dt1_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc = {hi, lo}; mul: hi=partial product, lo=multiplier; div: hi=rem, lo=quot.
module dt1_muldiv_step
  import dt1_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 i_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_opnd,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_diff;

  assign w_hi   = i_acc[2*WIDTH-1:WIDTH];
  assign w_lo   = i_acc[WIDTH-1:0];
  assign w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opnd} : '0);
  assign w_shl  = {w_hi, w_lo[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, i_opnd};

  always_comb begin
    o_acc = {w_sum, w_lo[WIDTH-1:1]};
    if (i_div) begin
      // borrow out of the trial subtract means restore
      if (w_diff[WIDTH])
        o_acc = {w_shl[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
      else
        o_acc = {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/dt1_muldiv.sv
// dt1 RV32M iterative multiply/divide unit: start/busy/done handshake,
// magnitude arithmetic with a final sign fix-up.
module dt1_muldiv
  import dt1_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CW-1:0]      r_cnt;
  md_op_e             r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_y;

  md_op_e             w_op;
  logic               w_an;
  logic               w_bn;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH-1:0]   w_min;
  logic               w_b_zero;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_spec_y;
  logic               w_accept;
  logic               w_last;
  logic               w_y_calc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_res;

  assign w_op     = md_op_e'(op);
  assign w_an     = op_sgn_a(w_op) & a[WIDTH-1];
  assign w_bn     = op_sgn_b(w_op) & b[WIDTH-1];
  assign w_ma     = w_an ? -a : a;
  assign w_mb     = w_bn ? -b : b;
  assign w_min    = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_b_zero = (b == '0);
  assign w_ovf    = (w_op == MD_DIV || w_op == MD_REM)
                  && a == w_min && b == '1;
  assign w_special = op[2] && (w_b_zero || w_ovf);

  always_comb begin
    w_spec_y = '0;
    if (w_b_zero)
      w_spec_y = op[1] ? a : '1;
    else
      w_spec_y = op[1] ? '0 : w_min;
  end

  assign w_accept = start && !kill && r_state != S_CALC;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_y_calc = r_state == S_CALC && w_last && !kill;

  dt1_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_op[2]),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt)
  );

  assign w_prod = r_neg_res ? -w_acc_nxt : w_acc_nxt;
  assign w_lo   = w_acc_nxt[WIDTH-1:0];
  assign w_hi   = w_acc_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      !r_op[2] && r_op[1:0] == 2'b00:
        w_res = w_prod[WIDTH-1:0];
      !r_op[2] && r_op[1:0] != 2'b00:
        w_res = w_prod[2*WIDTH-1:WIDTH];
      r_op[2] && !r_op[1]:
        w_res = r_neg_res ? -w_lo : w_lo;
      r_op[2] && r_op[1]:
        w_res = r_neg_rem ? -w_hi : w_hi;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_FIN: begin
        w_state_nxt = S_IDLE;
        if (w_accept)
          w_state_nxt = w_special ? S_FIN : S_CALC;
      end
      S_CALC:
        if (w_last) w_state_nxt = S_FIN;
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= MD_MUL;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_y       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op      <= w_op;
        r_cnt     <= '0;
        r_acc     <= {{WIDTH{1'b0}}, w_ma};
        r_opnd    <= w_mb;
        r_neg_res <= w_an ^ w_bn;
        r_neg_rem <= w_an;
        if (w_special) r_y <= w_spec_y;
      end else if (r_state == S_CALC && !kill) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_y_calc) r_y <= w_res;
      end
    end
  end

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_FIN);
  assign y    = r_y;

endmodule
